uio_bus_arbiter: RTL

// Shares the 8-bit bidirectional uio pad bus (uio_in/uio_out/uio_oe) of the top-level tt_um wrapper

---
 rtl/uio_bus_arbiter_pkg.sv | 17 +
 rtl/uio_bus_arbiter_rr_picker.sv | 33 +++
 rtl/uio_bus_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/uio_bus_arbiter_pkg.sv
// Shared types and constants for the uio pad-bus arbiter.
package uio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } state_t;

  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 8;

  // Per-pad output-enable values, replicated to the bus width at the use site.
  localparam logic OE_ALL  = 1'b1;
  localparam logic OE_NONE = 1'b0;

endpackage

// File: rtl/uio_bus_arbiter_rr_picker.sv
// Round-robin picker: first set request at or above ptr, wrapping modulo N.
module rr_picker #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic          any
);

  logic [2*N-1:0] dbl;
  int             sel;
  logic           found;

  // The doubled vector turns the wrap-around search into a plain window [ptr, ptr+N).
  always_comb begin
    dbl   = {req, req};
    sel   = 0;
    found = 1'b0;
    for (int k = 2*N-1; k >= 0; k--) begin
      if (dbl[k] && (k >= int'(ptr)) && (k < int'(ptr) + N)) begin
        sel   = k;
        found = 1'b1;
      end
    end
    any = found;
    for (int i = 0; i < N; i++) begin
      onehot[i] = found && ((sel == i) || (sel == i + N));
    end
  end

endmodule

// File: rtl/uio_bus_arbiter.sv
// Round-robin owner of the uio pad bus with turnaround cycle and hold limit.
module uio_bus_arbiter
  import uio_arb_pkg::*;
#(
  parameter int NREQ     = NREQ_DEF,
  parameter int WIDTH    = WIDTH_DEF,
  parameter int MAX_HOLD = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       wr,
  input  logic [NREQ-1:0]       last,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic [WIDTH-1:0]      rdata,
  output logic                  rvalid,
  input  logic [WIDTH-1:0]      uio_in,
  output logic [WIDTH-1:0]      uio_out,
  output logic [WIDTH-1:0]      uio_oe
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state_reg, state_next;
  logic [NREQ-1:0] gnt_reg, gnt_next;
  logic [PW-1:0]   ptr_reg, ptr_next;
  logic [7:0]      hold_cnt_reg, hold_cnt_next;
  logic [WIDTH-1:0] rdata_reg, rdata_next;
  logic            rvalid_reg, rvalid_next;

  logic [NREQ-1:0]  pick_onehot;
  logic             pick_any;
  logic [PW-1:0]    owner_idx;
  logic             own_req, own_wr, own_last;
  logic [WIDTH-1:0] own_wdata;
  logic             xfer, release_now;

  rr_picker #(.N(NREQ), .PW(PW)) u_picker (
    .req    (req),
    .ptr    (ptr_reg),
    .onehot (pick_onehot),
    .any    (pick_any)
  );

  always_comb begin
    owner_idx = '0;
    own_req   = 1'b0;
    own_wr    = 1'b0;
    own_last  = 1'b0;
    own_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_reg[i]) begin
        owner_idx = PW'(i);
        own_req   = req[i];
        own_wr    = wr[i];
        own_last  = last[i];
        own_wdata = wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  // ena is folded in so the pads fall back to input the moment the design is deselected.
  assign xfer        = (state_reg == OWN) && own_req && ena;
  assign release_now = !own_req || own_last || (int'(hold_cnt_reg) >= MAX_HOLD - 1);

  assign uio_oe  = (xfer && own_wr) ? {WIDTH{OE_ALL}} : {WIDTH{OE_NONE}};
  assign uio_out = (xfer && own_wr) ? own_wdata : '0;
  assign gnt     = gnt_reg;
  assign busy    = (state_reg != IDLE);
  assign rdata   = rdata_reg;
  assign rvalid  = rvalid_reg;

  always_comb begin
    state_next    = state_reg;
    gnt_next      = gnt_reg;
    ptr_next      = ptr_reg;
    hold_cnt_next = hold_cnt_reg;
    rdata_next    = rdata_reg;
    rvalid_next   = 1'b0;
    if (!ena) begin
      state_next = IDLE;
      gnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE, TURN: begin
          if (pick_any) begin
            state_next    = OWN;
            gnt_next      = pick_onehot;
            hold_cnt_next = '0;
          end else begin
            state_next = IDLE;
          end
        end
        OWN: begin
          if (xfer && !own_wr) begin
            rdata_next  = uio_in;
            rvalid_next = 1'b1;
          end
          if (xfer && hold_cnt_reg != 8'hFF) begin
            hold_cnt_next = hold_cnt_reg + 8'd1;
          end
          if (release_now) begin
            state_next = TURN;
            gnt_next   = '0;
            ptr_next   = (int'(owner_idx) == NREQ - 1) ? '0 : owner_idx + PW'(1);
          end
        end
        default: begin
          state_next = IDLE;
          gnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      gnt_reg      <= '0;
      ptr_reg      <= '0;
      hold_cnt_reg <= '0;
      rdata_reg    <= '0;
      rvalid_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      gnt_reg      <= gnt_next;
      ptr_reg      <= ptr_next;
      hold_cnt_reg <= hold_cnt_next;
      rdata_reg    <= rdata_next;
      rvalid_reg   <= rvalid_next;
    end
  end

endmodule
